muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Function : RV32M multiply/divide unit; radix-2 shift-add multiply and
//            restoring divide on magnitudes with sign fix-up at the end.
//            Define FAST_MUL_EN for a single-cycle multiplier on MUL* ops.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'(XLEN - 1);

    state_t            state_q;
    logic              busy_q, valid_q, neg_q, dz_q;
    logic [2:0]        op_q;
    logic [4:0]        cnt_q;
    logic [XLEN-1:0]   result_q, mplier_q, divisor_q, quo_q, rem_q;
    logic [2*XLEN-1:0] prod_q, mcand_q;

    logic              w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_quo_fix, w_rem_fix, w_result;
    logic [XLEN:0]     w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_prod_fix;

    // Only the 10xxx codes carry an M-extension operation.
    assign w_accept = start && !busy_q && !valid_q && (alu_control[4:3] == 2'b10)
                      && (state_q == S_IDLE);

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (alu_control[2:0])
            3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
    end

    assign w_a_neg = w_a_signed & operand_a[XLEN-1];
    assign w_b_neg = w_b_signed & operand_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -operand_a : operand_a;
    assign w_b_mag = w_b_neg ? -operand_b : operand_b;

    // A negative trial difference means this quotient bit is 0; keep the shifted remainder.
    assign w_rem_sh = {rem_q, quo_q[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, divisor_q};

    assign w_prod_fix = neg_q ? -prod_q : prod_q;
    assign w_quo_fix  = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
    assign w_rem_fix  = neg_q ? -rem_q : rem_q;

    always_comb begin
        w_result = w_prod_fix[XLEN-1:0];
        case (op_q)
            3'b000:                 w_result = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = w_quo_fix;
            default:                w_result = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (w_accept) begin
                        op_q      <= alu_control[2:0];
                        // Remainder follows the dividend sign; everything else the sign product.
                        neg_q     <= (alu_control[2:1] == 2'b11) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        dz_q      <= (operand_b == '0);
                        cnt_q     <= '0;
                        prod_q    <= '0;
                        mcand_q   <= {{XLEN{1'b0}}, w_a_mag};
                        mplier_q  <= w_b_mag;
                        divisor_q <= w_b_mag;
                        quo_q     <= w_a_mag;
                        rem_q     <= '0;
                        if (alu_control[2]) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                        end else begin
`ifdef FAST_MUL_EN
                            prod_q  <= {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
                            state_q <= S_DONE;
`else
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == c_LAST_ITER) begin
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_q <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ~w_diff[XLEN]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == c_LAST_ITER) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    result_q <= w_result;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule
`default_nettype wire
